// File: rtl/instr_encoder_if.sv
// -----------------------------------------------------------------------------
// instr_encoder_if
//
// Operand-bundle handshake between an instruction producer and instr_encoder.
// The producer presents one instruction per transfer as an operation ID plus
// raw MIPS operand fields. A transfer happens on a rising clock edge where
// in_valid and in_ready are both high.
//
// Signals:
//   in_valid  producer -> encoder  bundle valid
//   in_ready  encoder  -> producer encoder can accept this cycle
//   in_last   producer -> encoder  bundle is the final instruction
//   op_id     producer -> encoder  operation select (5 bits)
//   rs/rt/rd/sa producer -> encoder register and shift-amount fields
//   imm       producer -> encoder  16-bit I-type immediate
//   target    producer -> encoder  26-bit J-type target
//
// Modports: master = producer side, slave = encoder side.
// -----------------------------------------------------------------------------
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [4:0]  op_id;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] imm;
    logic [25:0] target;

    modport master (
        output in_valid, in_last, op_id, rs, rt, rd, sa, imm, target,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_last, op_id, rs, rt, rd, sa, imm, target,
        output in_ready
    );
endinterface

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Builds programs for the single-cycle MIPS core in hardware. Each accepted
// operand bundle is encoded into a 32-bit MIPS word and written to instruction
// memory at sequential word addresses starting at BASE_ADDR.
//
// Parameters:
//   BASE_ADDR  byte address of the first written word
//   ADDR_W     word-index width, capacity DEPTH = 2**ADDR_W words
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   start       pulse: clears count/flags and opens a load session
//   in_bus      operand bundle handshake (instr_encoder_if.slave)
//   imem_we     one-cycle write strobe per word
//   imem_addr   byte address BASE_ADDR + 4*index
//   imem_wdata  encoded instruction word
//   count       words written this session (updates as each strobe ends)
//   done        session complete
//   full        capacity reached
//   err         illegal op_id seen
//
// Optional feature (macro INSTR_ENCODER_NOP_PAD_EN):
//   When defined, a final instruction that leaves free slots sends the FSM to
//   a PAD state that fills every remaining index with 32'h0 (sll $0,$0,0),
//   one word per cycle, then finishes with full=1.
// -----------------------------------------------------------------------------
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    instr_encoder_if.slave    in_bus,
    output logic              imem_we,
    output logic [31:0]       imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              full,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    localparam logic [1:0] KIND_ILL = 2'd0;
    localparam logic [1:0] KIND_R   = 2'd1;
    localparam logic [1:0] KIND_J   = 2'd2;
    localparam logic [1:0] KIND_I   = 2'd3;

`ifdef INSTR_ENCODER_NOP_PAD_EN
    typedef enum logic [2:0] {ST_IDLE, ST_RUN, ST_DONE, ST_ERR, ST_PAD} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE, ST_ERR} state_t;
`endif

    // ------------------------------------------------------------------
    // Op table: encoding class and funct/opcode field for every op_id.
    // ------------------------------------------------------------------
    function automatic logic [1:0] op_kind(input int op);
        if (op < 16)
            return KIND_R;
        else if (op == 16)
            return KIND_J;
        else if (op <= 27)
            return KIND_I;
        else
            return KIND_ILL;
    endfunction

    function automatic logic [5:0] op_field(input int op);
        case (op)
            0:       return 6'd0;   // sll
            1:       return 6'd2;   // srl
            2:       return 6'd3;   // sra
            3:       return 6'd4;   // sllv
            4:       return 6'd6;   // srlv
            5:       return 6'd7;   // srav
            6:       return 6'd32;  // add
            7:       return 6'd33;  // addu
            8:       return 6'd34;  // sub
            9:       return 6'd35;  // subu
            10:      return 6'd36;  // and
            11:      return 6'd37;  // or
            12:      return 6'd38;  // xor
            13:      return 6'd39;  // nor
            14:      return 6'd42;  // slt
            15:      return 6'd43;  // sltu
            16:      return 6'd2;   // j
            17:      return 6'd4;   // beq
            18:      return 6'd5;   // bne
            19:      return 6'd8;   // addi
            20:      return 6'd9;   // addiu
            21:      return 6'd10;  // slti
            22:      return 6'd11;  // sltiu
            23:      return 6'd12;  // andi
            24:      return 6'd13;  // ori
            25:      return 6'd14;  // xori
            26:      return 6'd35;  // lw
            27:      return 6'd43;  // sw
            default: return 6'd0;
        endcase
    endfunction

    logic [5:0] field_tbl [32];
    logic [1:0] kind_tbl  [32];

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_op_tbl
            assign field_tbl[gi] = op_field(gi);
            assign kind_tbl[gi]  = op_kind(gi);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Combinational encoder for the bundle currently on the bus.
    // ------------------------------------------------------------------
    logic [5:0]  field_sel;
    logic [1:0]  kind_sel;
    logic [4:0]  rs_eff;
    logic [4:0]  sa_eff;
    logic [31:0] enc_word;
    logic        op_legal;

    always_comb begin
        field_sel = field_tbl[in_bus.op_id];
        kind_sel  = kind_tbl[in_bus.op_id];
        // Constant shifts (sll/srl/sra) have no rs operand; every other
        // R-type op has no shift amount.
        rs_eff    = (in_bus.op_id <= 5'd2) ? 5'd0 : in_bus.rs;
        sa_eff    = (in_bus.op_id <= 5'd2) ? in_bus.sa : 5'd0;
        enc_word  = 32'h0;
        op_legal  = 1'b1;
        case (kind_sel)
            KIND_R:  enc_word = {6'b0, rs_eff, in_bus.rt, in_bus.rd, sa_eff, field_sel};
            KIND_J:  enc_word = {field_sel, in_bus.target};
            KIND_I:  enc_word = {field_sel, in_bus.rs, in_bus.rt, in_bus.imm};
            default: op_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_t            state_reg,    state_next;
    logic [ADDR_W-1:0] idx_reg,      idx_next;
    logic              in_ready_reg, in_ready_next;
    logic              we_reg,       we_next;
    logic [31:0]       addr_reg,     addr_next;
    logic [31:0]       wdata_reg,    wdata_next;
    logic [ADDR_W:0]   count_reg,    count_next;
    logic              done_reg,     done_next;
    logic              full_reg,     full_next;
    logic              err_reg,      err_next;

    logic              fire;
    logic [31:0]       slot_addr;

    assign fire      = in_bus.in_valid & in_ready_reg;
    assign slot_addr = BASE_ADDR + (32'(idx_reg) << 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= '0;
            in_ready_reg <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= BASE_ADDR;
            wdata_reg    <= 32'h0;
            count_reg    <= '0;
            done_reg     <= 1'b0;
            full_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            in_ready_reg <= in_ready_next;
            we_reg       <= we_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            count_reg    <= count_next;
            done_reg     <= done_next;
            full_reg     <= full_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        we_next    = 1'b0;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        // count follows the strobe: a word is counted as its strobe cycle ends.
        count_next = count_reg + (ADDR_W + 1)'(we_reg);
        done_next  = done_reg;
        full_next  = full_reg;
        err_next   = err_reg;

        if (start) begin
            // Overrides everything, including a transfer in this same cycle
            // and the count increment of a strobe that is just finishing.
            state_next = ST_RUN;
            idx_next   = '0;
            count_next = '0;
            done_next  = 1'b0;
            full_next  = 1'b0;
            err_next   = 1'b0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (fire) begin
                        if (op_legal) begin
                            we_next    = 1'b1;
                            addr_next  = slot_addr;
                            wdata_next = enc_word;
                            idx_next   = idx_reg + ADDR_W'(1);
                            // Last slot wins over in_last: both end with full=1.
                            if (idx_reg == LAST_IDX) begin
                                state_next = ST_DONE;
                                done_next  = 1'b1;
                                full_next  = 1'b1;
                            end else if (in_bus.in_last) begin
`ifdef INSTR_ENCODER_NOP_PAD_EN
                                state_next = ST_PAD;
`else
                                state_next = ST_DONE;
                                done_next  = 1'b1;
`endif
                            end
                        end else begin
                            state_next = ST_ERR;
                            err_next   = 1'b1;
                        end
                    end
                end
`ifdef INSTR_ENCODER_NOP_PAD_EN
                ST_PAD: begin
                    we_next    = 1'b1;
                    addr_next  = slot_addr;
                    wdata_next = 32'h0;
                    idx_next   = idx_reg + ADDR_W'(1);
                    if (idx_reg == LAST_IDX) begin
                        state_next = ST_DONE;
                        done_next  = 1'b1;
                        full_next  = 1'b1;
                    end
                end
`endif
                default: begin
                    // IDLE, DONE and ERR hold until start.
                    state_next = state_reg;
                end
            endcase
        end

        // Registered ready: it reflects the state entered at this edge.
        in_ready_next = (state_next == ST_RUN);
    end

    assign in_bus.in_ready = in_ready_reg;
    assign imem_we         = we_reg;
    assign imem_addr       = addr_reg;
    assign imem_wdata      = wdata_reg;
    assign count           = count_reg;
    assign done            = done_reg;
    assign full            = full_reg;
    assign err             = err_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//
// Directed and randomized sessions against instr_encoder (ADDR_W=2, DEPTH=4).
// Expected words come from an arithmetic reference encoder built from the MIPS
// field layout; expected write sequences, flags and counts come from a
// session-level model kept in queues.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

    localparam int          ADDR_W = 2;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] BASE   = 32'h0040_0000;

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_DONE = 2;
    localparam int S_ERR  = 3;

    localparam int R_FUNCT [16] = '{0, 2, 3, 4, 6, 7, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43};
    localparam int I_OPC   [11] = '{4, 5, 8, 9, 10, 11, 12, 13, 14, 35, 43};

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              imem_we;
    logic [31:0]       imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              done;
    logic              full;
    logic              err;

    instr_encoder_if bus ();

    instr_encoder #(
        .BASE_ADDR (BASE),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_bus     (bus),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .done       (done),
        .full       (full),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Observed writes
    logic [31:0] got_a [$];
    logic [31:0] got_d [$];
    int          got_c [$];
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            got_a.push_back(imem_addr);
            got_d.push_back(imem_wdata);
            got_c.push_back(cyc);
        end
    end

    // Session model
    logic [31:0] exp_a [$];
    logic [31:0] exp_d [$];
    int m_state = S_IDLE;
    int m_idx   = 0;
    bit m_done  = 0;
    bit m_full  = 0;
    bit m_err   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {legal, word}
    function automatic logic [32:0] ref_encode(input int op, input int rs, input int rt,
                                               input int rd, input int sa, input int imm,
                                               input int tgt);
        logic [31:0] w;
        if (op < 16) begin
            w = 32'(R_FUNCT[op]) | (32'(rt) << 16) | (32'(rd) << 11);
            if (op <= 2) w = w | (32'(sa) << 6);
            else         w = w | (32'(rs) << 21);
            return {1'b1, w};
        end else if (op == 16) begin
            return {1'b1, (32'd2 << 26) | 32'(tgt)};
        end else if (op <= 27) begin
            w = (32'(I_OPC[op-17]) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
            return {1'b1, w};
        end
        return 33'h0;
    endfunction

    task automatic clear_queues();
        got_a.delete(); got_d.delete(); got_c.delete();
        exp_a.delete(); exp_d.delete();
    endtask

    // Called at a falling edge; returns at a falling edge with the session open.
    task automatic do_start();
        #2;
        clear_queues();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        m_state = S_RUN; m_idx = 0; m_done = 0; m_full = 0; m_err = 0;
        @(negedge clk);
    endtask

    task automatic send(input int op, input int rs, input int rt, input int rd, input int sa,
                        input int imm, input int tgt, input bit last, input string tag);
        logic [32:0] e;
        logic [31:0] a;
        e = ref_encode(op, rs, rt, rd, sa, imm, tgt);
        chk({tag, ".ready"}, 64'(bus.in_ready), 64'(1));
        bus.op_id = 5'(op); bus.rs = 5'(rs); bus.rt = 5'(rt); bus.rd = 5'(rd);
        bus.sa = 5'(sa); bus.imm = 16'(imm); bus.target = 26'(tgt);
        bus.in_last = last; bus.in_valid = 1'b1;
        @(posedge clk);
        a = BASE + 32'(m_idx * 4);
        if (!e[32]) begin
            m_err = 1; m_state = S_ERR;
        end else begin
            exp_a.push_back(a); exp_d.push_back(e[31:0]);
            if (m_idx == DEPTH - 1) begin
                m_full = 1; m_done = 1; m_state = S_DONE;
            end else if (last) begin
`ifdef INSTR_ENCODER_NOP_PAD_EN
                for (int p = m_idx + 1; p < DEPTH; p++) begin
                    exp_a.push_back(BASE + 32'(p * 4));
                    exp_d.push_back(32'h0);
                end
                m_full = 1;
`endif
                m_done = 1; m_state = S_DONE;
            end
            m_idx++;
        end
        #1;
        chk({tag, ".we"}, 64'(imem_we), 64'(e[32]));
        if (e[32]) begin
            chk({tag, ".addr"}, 64'(imem_addr), 64'(a));
            chk({tag, ".wdata"}, 64'(imem_wdata), 64'(e[31:0]));
        end
        $display("xfer %s op=%0d last=%0d legal=%0d addr=%h word=%h", tag, op, last, e[32], a, e[31:0]);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
    endtask

    task automatic settle_check(input string tag);
        int n;
        repeat (DEPTH + 3) @(negedge clk);
        chk({tag, ".nwr"}, 64'(got_a.size()), 64'(exp_a.size()));
        n = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s.wa%0d", tag, i), 64'(got_a[i]), 64'(exp_a[i]));
            chk($sformatf("%s.wd%0d", tag, i), 64'(got_d[i]), 64'(exp_d[i]));
        end
        chk({tag, ".count"}, 64'(count), 64'(exp_a.size()));
        chk({tag, ".done"}, 64'(done), 64'(m_done));
        chk({tag, ".full"}, 64'(full), 64'(m_full));
        chk({tag, ".err"}, 64'(err), 64'(m_err));
        chk({tag, ".ready"}, 64'(bus.in_ready), 64'(m_state == S_RUN));
        $display("session %s writes=%0d count=%0d done=%0d full=%0d err=%0d",
                 tag, got_a.size(), count, done, full, err);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".we"}, 64'(imem_we), 64'(0));
        chk({tag, ".addr"}, 64'(imem_addr), 64'(BASE));
        chk({tag, ".wdata"}, 64'(imem_wdata), 64'(0));
        chk({tag, ".count"}, 64'(count), 64'(0));
        chk({tag, ".flags"}, 64'({done, full, err}), 64'(0));
        chk({tag, ".ready"}, 64'(bus.in_ready), 64'(0));
    endtask

    initial begin
        int op, len, fr;
        bit lst;
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.op_id = '0; bus.rs = '0;
        bus.rt = '0; bus.rd = '0; bus.sa = '0; bus.imm = '0; bus.target = '0;

        // Reset
        repeat (2) @(posedge clk);
        #1 chk_reset("reset");
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        chk("idle.ready", 64'(bus.in_ready), 64'(0));

        // Single add with in_last
        do_start();
        send(6, 1, 2, 3, 0, 0, 0, 1'b1, "add");
        settle_check("add");

        // sll ignores rs
        do_start();
        send(0, 7, 1, 2, 4, 0, 0, 1'b1, "sll");
        settle_check("sll");

        // Back-to-back lw, j, beq
        do_start();
        send(26, 29, 8, 0, 0, 16, 0, 1'b0, "lw");
        send(16, 0, 0, 0, 0, 0, 26'h40, 1'b0, "j");
        send(17, 1, 2, 0, 0, 16'hFFFF, 0, 1'b1, "beq");
        settle_check("b2b");
        chk("b2b.gap01", 64'(got_c[1] - got_c[0]), 64'(1));
        chk("b2b.gap12", 64'(got_c[2] - got_c[1]), 64'(1));

        // Fill to capacity without in_last, then with in_last on the last slot
        for (int pass = 0; pass < 2; pass++) begin
            do_start();
            for (int k = 0; k < DEPTH; k++)
                send(7 + k, k, k + 1, k + 2, 0, 0, 0, (pass == 1) && (k == DEPTH - 1),
                     $sformatf("fill%0d_%0d", pass, k));
            settle_check($sformatf("fill%0d", pass));
        end

        // Illegal op mid-session, then restart
        do_start();
        send(11, 3, 4, 5, 0, 0, 0, 1'b0, "or");
        send(29, 1, 1, 1, 1, 1, 1, 1'b0, "ill");
        settle_check("ill");
        do_start();
        chk("restart.err", 64'(err), 64'(0));
        chk("restart.count", 64'(count), 64'(0));
        chk("restart.ready", 64'(bus.in_ready), 64'(1));

        // Start during a pending strobe: write completes, count cleared
        send(20, 2, 3, 0, 0, 16'h1234, 0, 1'b1, "pend");
        do_start();
        settle_check("pend_restart");

        // Reset together with a transfer: nothing is written afterwards
        bus.op_id = 5'd6; bus.rs = 5'd1; bus.rt = 5'd2; bus.rd = 5'd3;
        bus.in_valid = 1'b1; rst = 1'b1;
        @(posedge clk);
        #1 chk_reset("rst_xfer");
        @(negedge clk);
        rst = 1'b0; bus.in_valid = 1'b0;
        m_state = S_IDLE; m_done = 0; m_full = 0; m_err = 0;
        clear_queues();
        settle_check("rst_xfer");

`ifdef INSTR_ENCODER_NOP_PAD_EN
        // Reset while padding
        do_start();
        send(6, 1, 2, 3, 0, 0, 0, 1'b1, "padrst");
        rst = 1'b1;
        @(posedge clk);
        #1 chk_reset("pad_rst");
        @(negedge clk) rst = 1'b0;
        m_state = S_IDLE; m_done = 0; m_full = 0; m_err = 0;
        clear_queues();
        settle_check("pad_rst");
`endif

        // Randomized sessions
        for (int s = 0; s < 24; s++) begin
            do_start();
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                if (m_state != S_RUN) break;
                if ($urandom_range(0, 9) == 0) op = 28 + $urandom_range(0, 3);
                else                           op = $urandom_range(0, 27);
                fr  = $urandom_range(0, 3);
                lst = (k == len - 1) && ($urandom_range(0, 1) == 1);
                send(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), $urandom_range(0, 65535),
                     $urandom_range(0, 32'h3FF_FFFF), lst, $sformatf("r%0d_%0d_f%0d", s, k, fr));
            end
            settle_check($sformatf("rand%0d", s));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
